mips_instr_encoder: RTL and testbench

//  Inverse of the control decoder: turns a symbolic instruction (selector + register/imm fields)

---
 rtl/mips_instr_encoder.sv | 176 +++++++++++++++++
 tb/tb_mips_instr_encoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder
//   Turns a symbolic instruction (selector plus register/immediate fields)
//   into a 32-bit MIPS word and streams it into instruction memory.
//   Writes start at a base address that is latched when a run starts.
//   A single registered output stage sits between the input and output
//   handshakes. A run is framed by start and a one-cycle done pulse.
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   start, base_addr  begin a run (IDLE only), first write address
//   in_valid/in_ready input handshake; in_last marks the final instruction
//   in_sel            instruction selector (0..24 legal, 25..31 illegal)
//   in_rs/rt/rd/shamt register and shift-amount fields
//   in_imm, in_target immediate/offset and jump target fields
//   out_valid/ready   IMEM write handshake
//   out_addr/out_data IMEM write address and encoded word
//   count             legal words accepted in this run
//   err               sticky illegal-selector flag, cleared on start
//   done              one-cycle pulse when the run has fully drained
module mips_instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [4:0]        in_sel,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic              done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [ADDR_W:0] MaxCnt = (ADDR_W+1)'(MAX_WORDS);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [31:0]       out_data_q, out_data_d;

  logic              accept;
  logic              legal;
  logic [31:0]       encoded;
  logic [ADDR_W:0]   count_inc;

  // Bubble-free input: a new word can enter whenever the output stage is
  // empty or is being emptied this very cycle.
  assign in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign count_inc = count_q + 1'b1;

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign count     = count_q;
  assign err       = err_q;
  // The run is over once DRAIN finds the output stage empty; the state
  // returns to IDLE on the same edge, so this is high for one cycle only.
  assign done      = (state_q == DRAIN) && !out_valid_q;

  // Selector to machine word. Shifts take no rs and the other R-types take
  // no shamt, so those fields are forced to zero rather than passed through.
  always_comb begin
    encoded = 32'h0;
    legal   = 1'b1;
    case (in_sel)
      5'd0:  encoded = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h20};
      5'd1:  encoded = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h21};
      5'd2:  encoded = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h22};
      5'd3:  encoded = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h23};
      5'd4:  encoded = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h24};
      5'd5:  encoded = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h25};
      5'd6:  encoded = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h26};
      5'd7:  encoded = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h27};
      5'd8:  encoded = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2A};
      5'd9:  encoded = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2B};
      5'd10: encoded = {6'h00, 5'd0, in_rt, in_rd, in_shamt, 6'h00};
      5'd11: encoded = {6'h00, 5'd0, in_rt, in_rd, in_shamt, 6'h02};
      5'd12: encoded = {6'h00, 5'd0, in_rt, in_rd, in_shamt, 6'h03};
      5'd13: encoded = {6'h09, in_rs, in_rt, in_imm};
      5'd14: encoded = {6'h0A, in_rs, in_rt, in_imm};
      5'd15: encoded = {6'h0B, in_rs, in_rt, in_imm};
      5'd16: encoded = {6'h0C, in_rs, in_rt, in_imm};
      5'd17: encoded = {6'h0D, in_rs, in_rt, in_imm};
      5'd18: encoded = {6'h0E, in_rs, in_rt, in_imm};
      5'd19: encoded = {6'h0F, 5'd0, in_rt, in_imm};
      5'd20: encoded = {6'h23, in_rs, in_rt, in_imm};
      5'd21: encoded = {6'h2B, in_rs, in_rt, in_imm};
      5'd22: encoded = {6'h04, in_rs, in_rt, in_imm};
      5'd23: encoded = {6'h05, in_rs, in_rt, in_imm};
      5'd24: encoded = {6'h02, in_target};
      default: legal = 1'b0;
    endcase
  end

  // Run control and output stage. A completed write empties the stage
  // unless a fresh word is loaded on the same cycle. Illegal selectors are
  // swallowed without a write but still honour in_last.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          base_d  = base_addr;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      RUN: begin
        if (accept) begin
          if (legal) begin
            out_valid_d = 1'b1;
            out_data_d  = encoded;
            out_addr_d  = base_q + count_q[ADDR_W-1:0];
            count_d     = count_inc;
          end else begin
            err_d = 1'b1;
          end
          if (in_last || (legal && count_inc == MaxCnt)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!out_valid_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb_mips_instr_encoder
//   Directed bench for mips_instr_encoder, built with MAX_WORDS=4 so the
//   word-limit and address-wrap behaviour can be reached in a short run.
module tb_mips_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [4:0]  in_sel, in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_addr;
  logic [31:0] out_data;
  logic [10:0] count;
  logic        err;
  logic        done;

  int checks = 0;
  int fails  = 0;

  mips_instr_encoder #(.ADDR_W(10), .MAX_WORDS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_sel(in_sel), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .count(count), .err(err), .done(done)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction on the input side.
  task automatic applyStimulus(input logic [4:0] sel, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd,
                               input logic [4:0] sh, input logic [15:0] imm,
                               input logic [25:0] tgt, input logic last);
    in_valid = 1'b1; in_sel = sel; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_imm = imm; in_target = tgt; in_last = last;
  endtask

  task automatic beginRun(input logic [9:0] base);
    start = 1'b1; base_addr = base;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    in_sel = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
    in_imm = '0; in_target = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err got %b want 0", err); end
    checks++; if (count !== 11'd0) begin fails++; $display("[TB] FAIL reset_count got %0d want 0", count); end
    checks++; if (out_addr !== 10'h0) begin fails++; $display("[TB] FAIL reset_addr got %h want 000", out_addr); end
    checks++; if (out_data !== 32'h0) begin fails++; $display("[TB] FAIL reset_data got %h want 00000000", out_data); end
  endtask

  // ADDU, SLL (rs forced to 0) and LW with in_last, then the done pulse.
  task automatic test_encode();
    beginRun(10'h010);
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL run_in_ready got %b want 1", in_ready); end
    applyStimulus(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    tick();
    checks++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL addu_valid got %b want 1", out_valid); end
    checks++; if (out_data !== 32'h00221821) begin fails++; $display("[TB] FAIL addu_data got %h want 00221821", out_data); end
    checks++; if (out_addr !== 10'h010) begin fails++; $display("[TB] FAIL addu_addr got %h want 010", out_addr); end
    checks++; if (count !== 11'd1) begin fails++; $display("[TB] FAIL addu_count got %0d want 1", count); end
    applyStimulus(5'd10, 5'd7, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0, 1'b0);
    tick();
    checks++; if (out_data !== 32'h00011100) begin fails++; $display("[TB] FAIL sll_data got %h want 00011100", out_data); end
    checks++; if (out_addr !== 10'h011) begin fails++; $display("[TB] FAIL sll_addr got %h want 011", out_addr); end
    applyStimulus(5'd20, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    #1;
    checks++; if (out_data !== 32'h8FA80004) begin fails++; $display("[TB] FAIL lw_data got %h want 8FA80004", out_data); end
    checks++; if (count !== 11'd3) begin fails++; $display("[TB] FAIL lw_count got %0d want 3", count); end
    checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL drain_in_ready got %b want 0", in_ready); end
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL early_done got %b want 0", done); end
    tick();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL lw_written got %b want 0", out_valid); end
    checks++; if (done !== 1'b1) begin fails++; $display("[TB] FAIL lw_done got %b want 1", done); end
    tick();
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL lw_done_pulse got %b want 0", done); end
  endtask

  // J as the only, final instruction of a run.
  task automatic test_jump_last();
    beginRun(10'h200);
    applyStimulus(5'd24, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_data !== 32'h08000010) begin fails++; $display("[TB] FAIL j_data got %h want 08000010", out_data); end
    checks++; if (out_addr !== 10'h200) begin fails++; $display("[TB] FAIL j_addr got %h want 200", out_addr); end
    tick();
    checks++; if (done !== 1'b1) begin fails++; $display("[TB] FAIL j_done got %b want 1", done); end
    tick();
    checks++; if (done !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("[TB] FAIL j_idle got done=%b in_ready=%b want 0 0", done, in_ready); end
  endtask

  // Output stalled for 3 cycles with a word waiting; start during RUN ignored.
  task automatic test_back_to_back();
    beginRun(10'h100);
    applyStimulus(5'd2, 5'd4, 5'd5, 5'd6, 5'd7, 16'h0, 26'h0, 1'b0);
    tick();
    checks++; if (out_data !== 32'h00853022) begin fails++; $display("[TB] FAIL sub_data got %h want 00853022", out_data); end
    out_ready = 1'b0; start = 1'b1; base_addr = 10'h3FF;
    applyStimulus(5'd19, 5'd3, 5'd9, 5'd0, 5'd0, 16'h1234, 26'h0, 1'b0);
    #1;
    checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL stall_in_ready got %b want 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h00853022 || out_addr !== 10'h100 || in_ready !== 1'b0) begin
        fails++;
        $display("[TB] FAIL stall_hold cycle %0d got valid=%b data=%h addr=%h in_ready=%b want 1 00853022 100 0", i, out_valid, out_data, out_addr, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL release_in_ready got %b want 1", in_ready); end
    tick();
    start = 1'b0;
    checks++; if (out_data !== 32'h3C091234 || out_addr !== 10'h101) begin fails++; $display("[TB] FAIL lui_word got %h@%h want 3C091234@101", out_data, out_addr); end
    checks++; if (count !== 11'd2) begin fails++; $display("[TB] FAIL lui_count got %0d want 2", count); end
    applyStimulus(5'd23, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_data !== 32'h1422FFFF || out_addr !== 10'h102) begin fails++; $display("[TB] FAIL bne_word got %h@%h want 1422FFFF@102", out_data, out_addr); end
    tick();
    checks++; if (done !== 1'b1) begin fails++; $display("[TB] FAIL b2b_done got %b want 1", done); end
    tick();
  endtask

  // Illegal selectors: consumed, no write, sticky err, in_last still ends run.
  task automatic test_illegal();
    beginRun(10'h020);
    checks++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL start_err got %b want 0", err); end
    applyStimulus(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    tick();
    applyStimulus(5'd27, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    tick();
    checks++; if (err !== 1'b1) begin fails++; $display("[TB] FAIL illegal_err got %b want 1", err); end
    checks++; if (count !== 11'd1 || out_valid !== 1'b0) begin fails++; $display("[TB] FAIL illegal_nowrite got count=%0d valid=%b want 1 0", count, out_valid); end
    applyStimulus(5'd17, 5'd2, 5'd3, 5'd0, 5'd0, 16'h00FF, 26'h0, 1'b0);
    tick();
    checks++; if (out_data !== 32'h344300FF || out_addr !== 10'h021) begin fails++; $display("[TB] FAIL ori_word got %h@%h want 344300FF@021", out_data, out_addr); end
    applyStimulus(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (done !== 1'b1 || count !== 11'd2) begin fails++; $display("[TB] FAIL illegal_last got done=%b count=%0d want 1 2", done, count); end
    tick();
    checks++; if (done !== 1'b0 || err !== 1'b1) begin fails++; $display("[TB] FAIL illegal_sticky got done=%b err=%b want 0 1", done, err); end
  endtask

  // Word limit of 4 with the address wrapping past 0x3FF.
  task automatic test_max_words();
    logic [9:0] expAddr [4];
    expAddr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    beginRun(10'h3FE);
    checks++; if (err !== 1'b0 || count !== 11'd0) begin fails++; $display("[TB] FAIL max_start got err=%b count=%0d want 0 0", err, count); end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(5'd0, 5'd1, 5'd2, 5'(i), 5'd0, 16'h0, 26'h0, 1'b0);
      tick();
      checks++;
      if (out_addr !== expAddr[i] || count !== 11'(i + 1)) begin
        fails++;
        $display("[TB] FAIL max_addr word %0d got %h count %0d want %h count %0d", i, out_addr, count, expAddr[i], i + 1);
      end
    end
    #1;
    checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL max_in_ready got %b want 0", in_ready); end
    in_valid = 1'b0;
    tick();
    checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("[TB] FAIL max_done got done=%b valid=%b want 1 0", done, out_valid); end
    tick();
  endtask

  // Reset while a write is pending and stalled.
  task automatic test_reset_midrun();
    beginRun(10'h055);
    out_ready = 1'b0;
    applyStimulus(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    tick();
    checks++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL pend_valid got %b want 1", out_valid); end
    in_valid = 1'b0; rst = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || count !== 11'd0 || done !== 1'b0) begin fails++; $display("[TB] FAIL midreset got valid=%b count=%0d done=%b want 0 0 0", out_valid, count, done); end
    rst = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (done !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("[TB] FAIL midreset_idle got done=%b in_ready=%b want 0 0", done, in_ready); end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_jump_last();
    test_back_to_back();
    test_illegal();
    test_max_words();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
